result_hex_display: RTL
=======================

Name: result_hex_display

Overview:
- Consumer end of the calculator result bus.
- Takes the 32-bit hexadecimal result word and drives an 8-digit, common-anode, time-multiplexed seven-segment display, one digit at a time.
- Captures the result word into a shadow register once per scan frame, so a display frame never shows a mix of old and new digits.
- Optionally blanks leading zero digits.

Parameters:
- SCAN_DIV, 100000: clock cycles each digit stays lit. Legal range is 1 or more.
- BLANK_LEADING, 1: 1 means leading zero digits (nibbles 7..1) are blanked; 0 means all 8 digits are always shown.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- result  input  32  calculator result word. Nibble i drives digit i; digit 0 is the rightmost.
- blank  input  1  1 turns all digits off. Scanning and capture continue underneath.
- an  output  8  digit enables, active low; an[i] lights digit i.
- seg  output  7  segment drive, active low, ordered {g,f,e,d,c,b,a}.
- dp  output  1  decimal point, active low. Held at 1 (off) at all times.
- frame_done  output  1  one-cycle pulse each time the scan wraps from digit 7 back to digit 0.

Behaviour:
- Reset, asynchronous and immediate, including mid-frame:
  - div_cnt=0, digit_idx=0, shadow=0
  - an=8'hFF, seg=7'h7F, dp=1, frame_done=0
- Divider:
  - div_cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - When div_cnt==SCAN_DIV-1, digit_idx advances: 0..7, then wraps from 7 to 0.
  - With SCAN_DIV=1, digit_idx advances every cycle.
- Capture:
  - Whenever div_cnt==0 and digit_idx==0, shadow <= result at that edge.
  - This covers the first cycle after reset release and the start of every frame.
  - result is ignored at all other times.
- frame_done:
  - Registered.
  - Set to 1 at the edge where digit_idx goes from 7 to 0; cleared at the next edge.
  - Not asserted after reset release.
- Outputs are registered from the current (digit_idx, shadow, blank). Latency is 1 cycle: an/seg reflect the digit_idx value of the previous cycle.
  - Consequence: the first cycle of a frame still shows digit 7 of the old frame. This is accepted.
- Digit selection:
  - an = ~(8'b1 << digit_idx), unless that digit is blanked, in which case an = 8'hFF.
  - A digit is blanked if blank==1, or if BLANK_LEADING==1 and i>0 and shadow[31:4*i]==0.
  - Digit 0 is never blanked by the leading-zero rule, so a value of 0 displays "0".
- Segment codes (hex nibble -> seg, active low, gfedcba):
  - 0=40, 1=79, 2=24, 3=30
  - 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03
  - C=46, d=21, E=06, F=0E
  - When the digit is blanked, seg=7F.
- Simultaneous events:
  - A change on result in the same cycle as the capture is taken; the sampled value is what the result input holds at that edge.
  - A change on result mid-frame appears only from the next frame.
- blank acts combinationally into the output registers. No state is reset by blank.

Test Plan:
- rst held high for 3 cycles with result=32'h12345678 -> an=FF, seg=7F, frame_done=0 throughout. After release, SCAN_DIV=4, BLANK_LEADING=1:
  - the first frame shows digits 8,7,6,5,4,3,2,1;
  - the cycle after the first capture shows an=FE, seg=00 (digit 0 = '8');
  - each digit lasts 4 cycles.
- result=32'h000000A5 with BLANK_LEADING=1 -> over one frame:
  - only digits 0 (seg=12, '5') and 1 (seg=08, 'A') light;
  - digits 2..7 show an=FF, seg=7F.
- result=0 -> digit 0 shows seg=40, an=FE; all other slots are blank. With BLANK_LEADING=0, all 8 digits show seg=40.
- Change result from 32'h11111111 to 32'h22222222 while digit_idx=3 -> the rest of the frame still shows '1' (seg=79). After the next frame_done pulse, digits show '2' (seg=24).
- Check frame_done pulses -> exactly one per 32 cycles (SCAN_DIV=4), each 1 cycle wide, coincident with digit_idx returning to 0. Then assert rst mid-frame -> outputs immediately return to reset values, and scanning restarts at digit 0.
- Pulse blank high for 10 cycles -> an=FF for those cycles (plus 1 cycle of latency). The scan position after blank drops is the same as if blank had never been asserted.

Source files
------------

// File: rtl/result_hex_display.sv
// Drives an 8-digit common-anode seven-segment display from a 32-bit result word.
// The word is captured once per scan frame so a frame never mixes old and new digits.
module result_hex_display #(
  parameter int SCAN_DIV      = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result,
  input  logic        blank,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = 7'h40;
      4'h1:    code = 7'h79;
      4'h2:    code = 7'h24;
      4'h3:    code = 7'h30;
      4'h4:    code = 7'h19;
      4'h5:    code = 7'h12;
      4'h6:    code = 7'h02;
      4'h7:    code = 7'h78;
      4'h8:    code = 7'h00;
      4'h9:    code = 7'h10;
      4'hA:    code = 7'h08;
      4'hB:    code = 7'h03;
      4'hC:    code = 7'h46;
      4'hD:    code = 7'h21;
      4'hE:    code = 7'h06;
      4'hF:    code = 7'h0E;
      default: code = 7'h7F;
    endcase
    return code;
  endfunction

  // Digit idx is a leading zero when every nibble from idx upward is zero; digit 0 never is.
  function automatic logic leading_zero(input logic [31:0] value, input logic [2:0] idx);
    logic [31:0] upper;
    upper = value >> {idx, 2'b00};
    return (idx != 3'd0) && (upper == 32'd0);
  endfunction

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       digit_idx_q, digit_idx_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             frame_done_q, frame_done_d;
  logic             div_last_s;
  logic             digit_off_s;
  logic [3:0]       nibble_s;

  // Next-state for scan divider, shadow capture and registered display outputs.
  always_comb begin
    div_cnt_d    = div_cnt_q;
    digit_idx_d  = digit_idx_q;
    shadow_d     = shadow_q;
    frame_done_d = 1'b0;
    an_d         = 8'hFF;
    seg_d        = 7'h7F;

    div_last_s = (div_cnt_q == DIV_LAST);
    if (div_last_s) begin
      div_cnt_d   = '0;
      digit_idx_d = digit_idx_q + 3'd1;
    end else begin
      div_cnt_d   = div_cnt_q + DIV_W'(1);
      digit_idx_d = digit_idx_q;
    end

    if ((div_cnt_q == '0) && (digit_idx_q == 3'd0)) begin
      shadow_d = result;
    end else begin
      shadow_d = shadow_q;
    end

    frame_done_d = div_last_s && (digit_idx_q == 3'd7);

    // Outputs follow the current shadow, so a fresh capture shows one cycle later.
    nibble_s    = shadow_q[{digit_idx_q, 2'b00} +: 4];
    digit_off_s = blank || (BLANK_LEADING && leading_zero(shadow_q, digit_idx_q));
    if (digit_off_s) begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
    end else begin
      an_d  = ~(8'b0000_0001 << digit_idx_q);
      seg_d = hex_to_seg(nibble_s);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q    <= '0;
      digit_idx_q  <= 3'd0;
      shadow_q     <= 32'd0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      digit_idx_q  <= digit_idx_d;
      shadow_q     <= shadow_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = 1'b1;
  assign frame_done = frame_done_q;

endmodule
